// File: rtl/fetch_unit_pkg.sv
// Pipe_Buf_Reg_PKG: shared front-end pipeline buffer types and constants
package Pipe_Buf_Reg_PKG;

    localparam int PIPE_PC_W  = 9;
    localparam int PIPE_INS_W = 32;
    localparam int INSN_BYTES = 4;

    typedef struct packed {
        logic [PIPE_PC_W-1:0]  pc;
        logic [PIPE_INS_W-1:0] instr;
    } fq_entry_t;

    typedef struct packed {
        logic      valid;
        fq_entry_t ent;
    } if_id_buf_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: circular fetch queue with synchronous clear; pop on empty is ignored
module fetch_fifo #(
    parameter int W     = 41,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != CW'(DEPTH));
    assign head    = mem[rd_ptr];

    // pointers and occupancy; clear wins over any push or pop in the same cycle
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // entry storage; stale slots are never visible because count gates the head
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-based instruction fetch with redirect flush and sticky halt
module fetch_unit
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter int              FQ_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            redirect,
    input  logic [PC_W-1:0]                 redirect_pc,
    input  logic                            halt,
    output logic                            imem_req,
    output logic [PC_W-1:0]                 imem_addr,
    input  logic [INS_W-1:0]                imem_rdata,
    output logic                            out_valid,
    output logic [PC_W-1:0]                 out_pc,
    output logic [INS_W-1:0]                out_instr,
    input  logic                            out_ready,
    output logic                            halted,
    output logic [$clog2(FQ_DEPTH+1)-1:0]   fq_count
);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic            credit;
    logic            push;
    logic            pop;
    entry_t          head;

    // a slot is reserved for the outstanding response so a push never meets a full queue
    assign credit    = (int'(fq_count) + int'(inflight)) < FQ_DEPTH;
    assign imem_req  = !reset && !halted && !redirect && credit;
    assign imem_addr = fetch_pc;
    assign out_valid = !reset && !redirect && (fq_count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = inflight && !redirect;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    // fetch address, outstanding-request flag and sticky halt; reset beats redirect beats normal flow
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            halted   <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            if (imem_req) fetch_pc <= fetch_pc + PC_W'(INSN_BYTES);
            if (halt) halted <= 1'b1;
            inflight <= imem_req;
        end
        inflight_pc <= fetch_pc;
    end

    fetch_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .clear     (redirect),
        .push      (push),
        .push_data ({inflight_pc, imem_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (fq_count)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 9, program-counter width in bits.
REQ-002 Parameter INS_W, default 32, instruction width in bits.
REQ-003 Parameter FQ_DEPTH, default 4, fetch-queue entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0, fetch address after reset; PC_W bits, word-aligned.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 redirect  input  1  branch/jump taken; flush queue and refetch.
REQ-008 redirect_pc  input  PC_W  new fetch address, valid when redirect=1.
REQ-009 halt  input  1  stop issuing fetches; sticky once taken.
REQ-010 imem_req  output  1  instruction memory read request this cycle.
REQ-011 imem_addr  output  PC_W  read address, valid when imem_req=1.
REQ-012 imem_rdata  input  INS_W  read data; valid the cycle after imem_req.
REQ-013 out_valid  output  1  queue head holds an instruction for decode.
REQ-014 out_pc  output  PC_W  PC of the head instruction.
REQ-015 out_instr  output  INS_W  head instruction word.
REQ-016 out_ready  input  1  decode accepts the head (deasserted on decode stall).
REQ-017 halted  output  1  halt has taken effect.
REQ-018 fq_count  output  $clog2(FQ_DEPTH+1)  number of valid queue entries.

Function
REQ-019 fetch_pc register: imem_addr = fetch_pc; fetch_pc += 4 (mod 2^PC_W) on each cycle with imem_req=1.
REQ-020 imem_req = !reset && !halted && !redirect && (fq_count + inflight < FQ_DEPTH); inflight = 1-bit flag, set the cycle after an imem_req.
REQ-021 In the cycle after a request, if not discarded, {issued PC, imem_rdata} is pushed into the queue.
REQ-022 Latency: request in cycle n → out_valid=1 with that entry in cycle n+2.
REQ-023 Pop: entry leaves the queue on a cycle with out_valid && out_ready; strict FIFO order; no reordering or drop except on flush.
REQ-024 out_valid = (fq_count != 0) && !redirect; out_pc and out_instr are driven from the head entry, registered storage only.
REQ-025 Queue pointers wrap modulo FQ_DEPTH; a simultaneous push and pop leaves fq_count unchanged.
REQ-026 The credit rule guarantees no push when full; a pop when empty is ignored.
REQ-027 With FQ_DEPTH≥3 and out_ready held at 1, throughput is one instruction per cycle.
REQ-028 Redirect in cycle t:
  - queue cleared at the end of t;
  - any response arriving in t+1 is discarded;
  - fetch_pc <= redirect_pc;
  - imem_req=0 in t, imem_addr=redirect_pc with imem_req=1 in t+1.
REQ-029 Redirect has priority over pop and push in the same cycle; a head handed over in the redirect cycle is not consumed (out_valid=0).
REQ-030 halt=1 and redirect=0 → halted<=1.
  - Once halted: no new requests.
  - An in-flight response is still pushed.
  - The queue keeps draining.
REQ-031 halt and redirect in the same cycle → redirect is applied and halted is unchanged.
REQ-032 Redirect while halted → queue flushed and fetch_pc updated; no request is issued.

Reset
REQ-033 When reset=1 at a posedge:
  - fetch_pc <= RESET_PC;
  - queue emptied (fq_count=0), inflight=0, halted=0;
  - the next cycle's response is discarded.
REQ-034 During and after reset: out_valid=0, imem_req=0 (combinationally, while reset=1).
REQ-035 Reset has priority over redirect, halt and out_ready, including mid-operation.

Structure
REQ-036 fq_entry_t (packed struct of pc and instr) is defined in the shared pipeline package Pipe_Buf_Reg_PKG, next to the stage buffer typedefs.
REQ-037 The queue is sub-module fetch_fifo, parameterised by entry type width and depth, with push/pop/clear ports and count.
REQ-038 The credit, redirect and halt control logic lives in fetch_unit; no latches; all registers in always_ff.

Verification
REQ-039 Reset release, out_ready=1, imem returns word = address:
  - imem_addr sequence is 0, 4, 8, ...;
  - first out_valid with out_pc=0 two cycles after the first imem_req;
  - then one entry per cycle.
REQ-040 out_ready=0 from reset:
  - fq_count saturates at 4 and imem_req falls to 0 with fetch_pc=16;
  - raising out_ready drains 0, 4, 8, 12, 16 in order.
REQ-041 Redirect to 0x40 while fq_count=3 and a request is in flight:
  - the next cycle has fq_count=0 and imem_addr=0x40;
  - no stale PC ever appears on out_pc.
REQ-042 halt pulse at fetch_pc=0x20 with one request in flight:
  - the in-flight entry 0x1C is delivered;
  - no imem_req thereafter, halted=1;
  - the queue drains to fq_count=0.
REQ-043 Wrap-around, PC_W=9, RESET_PC=0x1F8: imem_addr sequence is 0x1F8, 0x1FC, 0x000, 0x004.
REQ-044 Reset asserted mid-stream with fq_count=2 → the next cycle has out_valid=0, fq_count=0, halted=0, imem_addr=RESET_PC.
